// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: passive checker for a VGA timing stream on the pixel clock.
// It locks onto hsync/vsync and reports the active-window coordinate and colour
// of each pixel, a per-frame pulse, and a saturating count of timing errors.
// Optional feature: define VGA_MON_CHECKSUM_EN to add a per-frame rotate-XOR
// checksum of active pixels on frame_sum_o (otherwise frame_sum_o is tied to 0).
module vga_sync_monitor #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic        locked_o,
  output logic        pixel_valid_o,
  output logic [11:0] x_o,
  output logic [10:0] y_o,
  output logic [11:0] pix_o,
  output logic        frame_done_o,
  output logic [15:0] err_count_o,
  output logic [11:0] frame_sum_o
);

  localparam logic [11:0] H_TOT = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [11:0] H_ST  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] H_SW  = 12'(H_SYNC);
  localparam logic [10:0] V_TOT = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [10:0] V_ST  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic        INACT = ~SYNC_POL;

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_e;

  logic        hs1_q, vs1_q, hs2_q, vs2_q;
  logic [11:0] rgb1_q;
  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d, hw_q, hw_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        hst_q, hst_d, vst_q, vst_d, varm_q, varm_d;
  logic        locked_q, pv_q, pv_d, fd_q, fd_d;
  logic [11:0] x_q, x_d, pix_q, pix_d;
  logic [10:0] y_q, y_d;
  logic [15:0] errc_q, errc_d;
  logic        hs_edge, vs_edge, err_line, err_frame, err_any;

  // Leading edge: S1 now at the asserted level, S2 (previous S1) was not.
  assign hs_edge = (hs1_q == SYNC_POL) && (hs2_q != SYNC_POL);
  assign vs_edge = (vs1_q == SYNC_POL) && (vs2_q != SYNC_POL);
  assign err_any = err_line || err_frame;

  // S1 input register and S2 edge-history register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs1_q  <= INACT;
      vs1_q  <= INACT;
      hs2_q  <= INACT;
      vs2_q  <= INACT;
      rgb1_q <= '0;
    end else begin
      hs1_q  <= hsync_i;
      vs1_q  <= vsync_i;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      rgb1_q <= {red_i, green_i, blue_i};
    end
  end

  // Line/frame counters and timing checks. hst/vst gate checking until a first
  // edge has started a measurement, so a reset mid-frame never reports errors.
  always_comb begin
    hcnt_d    = hcnt_q;
    hst_d     = hst_q;
    hw_d      = hw_q;
    vcnt_d    = vcnt_q;
    vst_d     = vst_q;
    varm_d    = varm_q;
    err_line  = 1'b0;
    err_frame = 1'b0;
    if (hs_edge) begin
      hcnt_d = '0;
      hst_d  = 1'b1;
      hw_d   = 12'd1;
      if (hst_q && (((hcnt_q + 12'd1) != H_TOT) || (hw_q != H_SW))) err_line = 1'b1;
    end else begin
      if ((hs1_q == SYNC_POL) && (hw_q != 12'hFFF)) hw_d = hw_q + 12'd1;
      if (hst_q) begin
        // Counted a full line past H_TOTAL with no edge: report once, then idle.
        if (hcnt_q == H_TOT) begin
          err_line = 1'b1;
          hst_d    = 1'b0;
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_q + 12'd1;
        end
      end
    end
    if (vs_edge && vst_q && ((vcnt_q + 11'd1) != V_TOT)) err_frame = 1'b1;
    if (hs_edge) begin
      if (vs_edge || varm_q) begin
        vcnt_d = '0;
        varm_d = 1'b0;
        vst_d  = 1'b1;
      end else if (vcnt_q != 11'h7FF) begin
        vcnt_d = vcnt_q + 11'd1;
      end
    end else if (vs_edge) begin
      varm_d = 1'b1;
    end
  end

  // Lock FSM next state, error counter and registered output values.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH:  if (vs_edge) state_d = MEASURE;
      MEASURE: if (err_any) state_d = SEARCH;
               else if (vs_edge) state_d = LOCKED;
      LOCKED:  if (err_any) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
    errc_d = errc_q;
    if (err_any && (errc_q != 16'hFFFF)) errc_d = errc_q + 16'd1;
    fd_d  = vs_edge && (state_d == LOCKED);
    pv_d  = (state_d == LOCKED) && (hcnt_d >= H_ST) && (hcnt_d < H_END) &&
            (vcnt_d >= V_ST) && (vcnt_d < V_END);
    x_d   = pv_d ? (hcnt_d - H_ST) : 12'd0;
    y_d   = pv_d ? (vcnt_d - V_ST) : 11'd0;
    pix_d = pv_d ? rgb1_q : 12'd0;
  end

  // State, counters and outputs; all update one clock after S1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SEARCH;
      hcnt_q   <= '0;
      hw_q     <= '0;
      hst_q    <= 1'b0;
      vcnt_q   <= '0;
      vst_q    <= 1'b0;
      varm_q   <= 1'b0;
      errc_q   <= '0;
      locked_q <= 1'b0;
      pv_q     <= 1'b0;
      fd_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      hw_q     <= hw_d;
      hst_q    <= hst_d;
      vcnt_q   <= vcnt_d;
      vst_q    <= vst_d;
      varm_q   <= varm_d;
      errc_q   <= errc_d;
      locked_q <= (state_d == LOCKED);
      pv_q     <= pv_d;
      fd_q     <= fd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_q    <= pix_d;
    end
  end

  assign locked_o      = locked_q;
  assign pixel_valid_o = pv_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign pix_o         = pix_q;
  assign frame_done_o  = fd_q;
  assign err_count_o   = errc_q;

`ifdef VGA_MON_CHECKSUM_EN
  logic [11:0] acc_q, acc_d, fsum_q, fsum_d;

  // Rotate-XOR accumulator over active pixels; snapshot at frame_done.
  always_comb begin
    acc_d  = acc_q;
    fsum_d = fsum_q;
    if (fd_d) begin
      fsum_d = acc_q;
      acc_d  = '0;
    end else if (state_d != LOCKED) begin
      acc_d = '0;
    end else if (pv_d) begin
      acc_d = {acc_q[10:0], acc_q[11]} ^ rgb1_q;
    end
  end

  // Checksum registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      fsum_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fsum_q <= fsum_d;
    end
  end

  assign frame_sum_o = fsum_q;
`else
  assign frame_sum_o = 12'd0;
`endif

endmodule
